// File: rtl/age_select_pipe.sv
// Age-ordered request selector: a balanced binary tree picks the oldest (or
// youngest) requesting slot using wrap-aware tag comparison. The winner is
// captured in a single output register stage with valid/ready handshake.
module age_select_pipe #(
  parameter int unsigned REQ_NUM     = 16,
  parameter int unsigned TAG_WIDTH   = 6,
  parameter bit          PICK_OLDEST = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [REQ_NUM-1:0]            req,
  input  logic [REQ_NUM*TAG_WIDTH-1:0]  i_tag,
  input  logic [REQ_NUM-1:0]            i_wrap,
  output logic [REQ_NUM-1:0]            gnt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(REQ_NUM)-1:0]    out_idx,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic                          out_wrap
);

  localparam int unsigned IDX_W = $clog2(REQ_NUM);
  localparam int unsigned NODES = 2 * REQ_NUM;

  logic                 win_valid;
  logic [IDX_W-1:0]     win_idx;
  logic [TAG_WIDTH-1:0] win_tag;
  logic                 win_wrap;
  logic                 in_ready;

  // True when entry A is strictly older than entry B (wrap bit flips the tag order).
  function automatic logic is_older(input logic wa, input logic [TAG_WIDTH-1:0] ta,
                                    input logic wb, input logic [TAG_WIDTH-1:0] tb);
    return (wa == wb) ? (ta < tb) : (ta > tb);
  endfunction

  // Heap-indexed selection tree: leaves at REQ_NUM.., root at node 1; left child
  // always covers lower slot indices, so ties resolve to the left.
  always_comb begin : sel_tree
    logic                 nv [NODES];
    logic [IDX_W-1:0]     ni [NODES];
    logic [TAG_WIDTH-1:0] nt [NODES];
    logic                 nw [NODES];
    logic                 take_r;
    for (int n = 0; n < int'(NODES); n++) begin
      nv[n] = 1'b0;
      ni[n] = '0;
      nt[n] = '0;
      nw[n] = 1'b0;
    end
    take_r = 1'b0;
    for (int i = 0; i < int'(REQ_NUM); i++) begin
      nv[int'(REQ_NUM) + i] = req[i];
      ni[int'(REQ_NUM) + i] = IDX_W'(i);
      nt[int'(REQ_NUM) + i] = i_tag[i*int'(TAG_WIDTH) +: TAG_WIDTH];
      nw[int'(REQ_NUM) + i] = i_wrap[i];
    end
    for (int n = int'(REQ_NUM) - 1; n >= 1; n--) begin
      if (PICK_OLDEST)
        take_r = nv[2*n+1] && (!nv[2*n] ||
                 is_older(nw[2*n+1], nt[2*n+1], nw[2*n], nt[2*n]));
      else
        take_r = nv[2*n+1] && (!nv[2*n] ||
                 is_older(nw[2*n], nt[2*n], nw[2*n+1], nt[2*n+1]));
      nv[n] = nv[2*n] | nv[2*n+1];
      ni[n] = take_r ? ni[2*n+1] : ni[2*n];
      nt[n] = take_r ? nt[2*n+1] : nt[2*n];
      nw[n] = take_r ? nw[2*n+1] : nw[2*n];
    end
    win_valid = nv[1];
    win_idx   = ni[1];
    win_tag   = nt[1];
    win_wrap  = nw[1];
  end

  assign in_ready = !out_valid | out_ready;

  // One-hot grant to the winner only when the output stage can take it.
  always_comb begin
    gnt = '0;
    if (!reset && !flush && in_ready && win_valid)
      gnt[win_idx] = 1'b1;
  end

  // Output stage: load on grant, drain on ready, squash on flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_tag   <= '0;
      out_wrap  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= win_valid;
      if (win_valid) begin
        out_idx  <= win_idx;
        out_tag  <= win_tag;
        out_wrap <= win_wrap;
      end
    end
  end

endmodule

// File: tb/tb_age_select_pipe.sv
// Directed and randomized checks for age_select_pipe.
module tb_age_select_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, flush, ready;
  logic [15:0] d_req, d_wrap;
  logic [95:0] d_tag;

  logic [15:0] gnt_o, gnt_y;
  logic        ov_o, ov_y, wrap_o, wrap_y;
  logic [3:0]  idx_o, idx_y;
  logic [5:0]  tag_o, tag_y;

  logic [63:0]  r_req, r_wrap;
  logic [383:0] r_tag;
  logic         r_flush, r_ready;

  logic [3:0]  g4;  logic ov4;  logic [1:0] idx4; logic [5:0] tag4;  logic wrap4;
  logic [31:0] g32; logic ov32; logic [4:0] idx32; logic [5:0] tag32; logic wrap32;
  logic [63:0] g64; logic ov64; logic [5:0] idx64; logic [5:0] tag64; logic wrap64;

  int total = 0;
  int bad   = 0;
  int seq [64];

  age_select_pipe #(.REQ_NUM(16), .TAG_WIDTH(6), .PICK_OLDEST(1'b1)) dut (
    .clock(clock), .reset(reset), .flush(flush), .req(d_req), .i_tag(d_tag),
    .i_wrap(d_wrap), .gnt(gnt_o), .out_valid(ov_o), .out_ready(ready),
    .out_idx(idx_o), .out_tag(tag_o), .out_wrap(wrap_o));

  age_select_pipe #(.REQ_NUM(16), .TAG_WIDTH(6), .PICK_OLDEST(1'b0)) dut_y (
    .clock(clock), .reset(reset), .flush(flush), .req(d_req), .i_tag(d_tag),
    .i_wrap(d_wrap), .gnt(gnt_y), .out_valid(ov_y), .out_ready(1'b1),
    .out_idx(idx_y), .out_tag(tag_y), .out_wrap(wrap_y));

  age_select_pipe #(.REQ_NUM(4), .TAG_WIDTH(6), .PICK_OLDEST(1'b1)) dut4 (
    .clock(clock), .reset(reset), .flush(r_flush), .req(r_req[3:0]), .i_tag(r_tag[23:0]),
    .i_wrap(r_wrap[3:0]), .gnt(g4), .out_valid(ov4), .out_ready(r_ready),
    .out_idx(idx4), .out_tag(tag4), .out_wrap(wrap4));

  age_select_pipe #(.REQ_NUM(32), .TAG_WIDTH(6), .PICK_OLDEST(1'b0)) dut32 (
    .clock(clock), .reset(reset), .flush(r_flush), .req(r_req[31:0]), .i_tag(r_tag[191:0]),
    .i_wrap(r_wrap[31:0]), .gnt(g32), .out_valid(ov32), .out_ready(r_ready),
    .out_idx(idx32), .out_tag(tag32), .out_wrap(wrap32));

  age_select_pipe #(.REQ_NUM(64), .TAG_WIDTH(6), .PICK_OLDEST(1'b1)) dut64 (
    .clock(clock), .reset(reset), .flush(r_flush), .req(r_req), .i_tag(r_tag),
    .i_wrap(r_wrap), .gnt(g64), .out_valid(ov64), .out_ready(r_ready),
    .out_idx(idx64), .out_tag(tag64), .out_wrap(wrap64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_tag(input int slot, input logic [5:0] v);
    d_tag[slot*6 +: 6] = v;
  endtask

  task automatic get_out(input int k, output logic [63:0] g, output logic v,
                         output logic [63:0] ix, output logic [63:0] t, output logic [63:0] w);
    case (k)
      0:       begin g = 64'(g4);  v = ov4;  ix = 64'(idx4);  t = 64'(tag4);  w = 64'(wrap4);  end
      1:       begin g = 64'(g32); v = ov32; ix = 64'(idx32); t = 64'(tag32); w = 64'(wrap32); end
      default: begin g = g64;      v = ov64; ix = 64'(idx64); t = 64'(tag64); w = 64'(wrap64); end
    endcase
  endtask

  // Reference: true sequence numbers, smallest = oldest, ties to lowest slot.
  function automatic int pick(input int n, input bit oldest);
    int best = -1;
    for (int i = 0; i < n; i++) begin
      if (r_req[i]) begin
        if (best < 0) best = i;
        else if (oldest ? (seq[i] < seq[best]) : (seq[i] > seq[best])) best = i;
      end
    end
    return best;
  endfunction

  logic [15:0] stall_req [3];
  int          mn    [3];
  bit          mold  [3];
  bit          mv    [3];
  int          midx  [3];
  int          mseq  [3];

  initial begin
    logic [63:0] g, ix, t, w;
    logic        v;
    stall_req[0] = 16'h0081; stall_req[1] = 16'hFFFF; stall_req[2] = 16'h0002;
    mn[0] = 4;  mn[1] = 32; mn[2] = 64;
    mold[0] = 1'b1; mold[1] = 1'b0; mold[2] = 1'b1;

    reset = 1'b1; flush = 1'b0; ready = 1'b1;
    d_req = 16'h00FF; d_tag = '0; d_wrap = '0;
    r_req = '0; r_tag = '0; r_wrap = '0; r_flush = 1'b0; r_ready = 1'b1;
    #2;
    check("rst_valid", 64'(ov_o), 64'd0);
    check("rst_idx",   64'(idx_o), 64'd0);
    check("rst_tag",   64'(tag_o), 64'd0);
    check("rst_wrap",  64'(wrap_o), 64'd0);
    check("rst_gnt",   64'(gnt_o), 64'd0);
    tick(); tick();
    reset = 1'b0; d_req = '0;

    // Basic oldest pick, one-cycle latency
    d_req = 16'h0081; set_tag(0, 6'd5); set_tag(7, 6'd3);
    #1 check("basic_gnt", 64'(gnt_o), 64'h0080);
    tick();
    check("basic_valid", 64'(ov_o), 64'd1);
    check("basic_idx", 64'(idx_o), 64'd7);
    check("basic_tag", 64'(tag_o), 64'd3);
    check("basic_wrap", 64'(wrap_o), 64'd0);

    // Wrap-aware ordering, both modes
    d_tag = '0; d_req = 16'h0003; set_tag(0, 6'd60); set_tag(1, 6'd2); d_wrap = 16'h0002;
    #1 check("wrap_gnt_old", 64'(gnt_o), 64'h0001);
    check("wrap_gnt_young", 64'(gnt_y), 64'h0002);
    tick();
    check("wrap_idx_old", 64'(idx_o), 64'd0);
    check("wrap_tag_old", 64'(tag_o), 64'd60);
    check("wrap_w_old", 64'(wrap_o), 64'd0);
    check("wrap_idx_young", 64'(idx_y), 64'd1);
    check("wrap_tag_young", 64'(tag_y), 64'd2);
    check("wrap_w_young", 64'(wrap_y), 64'd1);

    // Tie resolves to lower slot
    d_tag = '0; d_wrap = '0; set_tag(4, 6'd10); set_tag(9, 6'd10); d_req = 16'h0210;
    #1 check("tie_gnt", 64'(gnt_o), 64'h0010);
    check("tie_gnt_young", 64'(gnt_y), 64'h0010);
    tick();
    check("tie_idx", 64'(idx_o), 64'd4);

    // Stall: outputs hold, no grant while requests change
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d_req = stall_req[c]; set_tag(0, 6'(c + 1));
      #1 check("stall_gnt", 64'(gnt_o), 64'd0);
      tick();
      check("stall_valid", 64'(ov_o), 64'd1);
      check("stall_idx", 64'(idx_o), 64'd4);
      check("stall_tag", 64'(tag_o), 64'd10);
    end
    ready = 1'b1; d_req = 16'h0100; set_tag(8, 6'd7);
    #1 check("resume_gnt", 64'(gnt_o), 64'h0100);
    tick();
    check("resume_valid", 64'(ov_o), 64'd1);
    check("resume_idx", 64'(idx_o), 64'd8);
    check("resume_tag", 64'(tag_o), 64'd7);

    // Flush squashes grant and pending output even when stalled
    ready = 1'b0; d_req = 16'hFFFF; flush = 1'b1;
    #1 check("flush_gnt", 64'(gnt_o), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_valid", 64'(ov_o), 64'd0);

    // Drain with no request clears out_valid
    ready = 1'b1; d_tag = '0; d_req = 16'h0004;
    #1 check("single_gnt", 64'(gnt_o), 64'h0004);
    tick();
    check("single_idx", 64'(idx_o), 64'd2);
    d_req = '0;
    #1 check("idle_gnt", 64'(gnt_o), 64'd0);
    tick();
    check("idle_valid", 64'(ov_o), 64'd0);

    // Reset asserted mid-stall
    d_req = 16'h0020; set_tag(5, 6'd9);
    tick();
    check("pre_rst_idx", 64'(idx_o), 64'd5);
    ready = 1'b0; d_req = 16'h0003;
    tick();
    check("pre_rst_valid", 64'(ov_o), 64'd1);
    #2 reset = 1'b1;
    #1 check("midrst_valid", 64'(ov_o), 64'd0);
    check("midrst_idx", 64'(idx_o), 64'd0);
    check("midrst_tag", 64'(tag_o), 64'd0);
    check("midrst_gnt", 64'(gnt_o), 64'd0);
    tick();
    reset = 1'b0; d_req = 16'h0040; set_tag(6, 6'd1);
    #1 check("post_rst_gnt", 64'(gnt_o), 64'h0040);
    tick();
    check("post_rst_valid", 64'(ov_o), 64'd1);
    check("post_rst_idx", 64'(idx_o), 64'd6);
    d_req = '0;

    // Randomized run against sequence-number reference
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin mv[k] = 1'b0; midx[k] = 0; mseq[k] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int base;
      base = int'($urandom_range(0, 1023));
      for (int i = 0; i < 64; i++) begin
        seq[i] = base + int'($urandom_range(0, 62));
        r_tag[i*6 +: 6] = 6'(seq[i]);
        r_wrap[i] = seq[i][6];
      end
      case ($urandom_range(0, 9))
        0:       r_req = '0;
        1:       r_req = 64'(1) << $urandom_range(0, 63);
        2, 3:    r_req = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: r_req = {$urandom, $urandom};
      endcase
      r_flush = ($urandom_range(0, 19) == 0);
      r_ready = ($urandom_range(0, 9) < 7);
      #1;
      for (int k = 0; k < 3; k++) begin
        int  wn;
        bit  inr;
        wn  = pick(mn[k], mold[k]);
        inr = !mv[k] || r_ready;
        get_out(k, g, v, ix, t, w);
        check("r_gnt", g, (inr && !r_flush && wn >= 0) ? (64'(1) << wn) : 64'd0);
        check("r_onehot", 64'($onehot0(g)), 64'd1);
        if (r_flush) mv[k] = 1'b0;
        else if (inr) begin
          mv[k] = (wn >= 0);
          if (wn >= 0) begin midx[k] = wn; mseq[k] = seq[wn]; end
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        get_out(k, g, v, ix, t, w);
        check("r_valid", 64'(v), 64'(mv[k]));
        if (mv[k]) begin
          check("r_idx", ix, 64'(midx[k]));
          check("r_tag", t, 64'(mseq[k] & 63));
          check("r_wrap", w, 64'((mseq[k] >> 6) & 1));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/age_select_pipe.md
AGE_SELECT_PIPE -- requirements
Module: age_select_pipe

Interface
REQ-001 Parameter REQ_NUM, default 16: number of request slots; any power of two, 4..64.
REQ-002 Parameter TAG_WIDTH, default 6: width of the age tag per slot, excluding the wrap bit.
REQ-003 Parameter PICK_OLDEST, default 1: 1 selects the oldest request; 0 selects the youngest.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous squash of the pending output and the current grant.
REQ-007 req  input  REQ_NUM  per-slot request valid.
REQ-008 i_tag  input  REQ_NUM x TAG_WIDTH  per-slot age tag.
REQ-009 i_wrap  input  REQ_NUM  per-slot wrap bit.
REQ-010 gnt  output  REQ_NUM  one-hot combinational grant to the winning slot.
REQ-011 out_valid  output  1  registered winner valid.
REQ-012 out_ready  input  1  downstream accepts the winner.
REQ-013 out_idx  output  clog2(REQ_NUM)  registered winner slot index.
REQ-014 out_tag  output  TAG_WIDTH  registered winner tag.
REQ-015 out_wrap  output  1  registered winner wrap bit.

Function
REQ-016 Age order: A is older than B if (wrap_A==wrap_B and tag_A<tag_B) or (wrap_A!=wrap_B and tag_A>tag_B).
REQ-017 Equal wrap and equal tag: the lower slot index wins, in both modes.
REQ-018 The wrap bit travels with the selected tag through every tree level; the winning index, tag and wrap always come from the same slot.
REQ-019 The selection tree is a balanced binary tree of log2(REQ_NUM) levels; a pair with only one requester forwards that requester; a pair with none forwards "no request".
REQ-020 in_ready (internal) = !out_valid | out_ready.
REQ-021 gnt is one-hot at the winning slot when in_ready=1, flush=0 and |req=1; otherwise gnt=0.
REQ-022 A grant in cycle T loads out_idx/out_tag/out_wrap with the winner and sets out_valid=1 at T+1; latency from req to out_valid is 1 cycle.
REQ-023 out_valid=1 and out_ready=0: outputs hold stable, gnt=0, and req/tag changes are ignored.
REQ-024 out_valid=1, out_ready=1 and a new winner present: back-to-back transfer; the next winner is loaded in the same edge and out_valid stays 1.
REQ-025 out_ready=1 with no request: out_valid clears at the next edge.
REQ-026 flush=1: gnt=0 in that cycle; out_valid clears at the next edge regardless of out_ready; data registers may hold stale values.
REQ-027 When out_valid=0, out_idx/out_tag/out_wrap are don't-care except directly after reset.
REQ-028 Requests never lose an index: gnt and out_idx always name a slot with req=1 at grant time.

Reset
REQ-029 Asynchronous assertion of reset forces out_valid=0, out_idx=0, out_tag=0 and out_wrap=0 immediately; gnt=0 while reset=1.
REQ-030 Reset asserted while out_valid=1 and stalled drops the pending winner; after reset deassertion the first grant occurs in the first cycle with |req=1.

Verification
REQ-031 REQ_NUM=16, PICK_OLDEST=1, req=0x0081, tag[0]=5, tag[7]=3, wraps 0 -> gnt=0x0080; next cycle out_valid=1, out_idx=7, out_tag=3.
REQ-032 Wrap case: req=0x0003, slot0 tag=60 wrap=0, slot1 tag=2 wrap=1 -> slot0 wins (gnt=0x0001); with PICK_OLDEST=0 -> slot1 wins.
REQ-033 Tie: slots 4 and 9 with tag=10 and equal wrap -> gnt=0x0010, out_idx=4.
REQ-034 Stall: out_valid=1, out_ready=0 for 3 cycles while req changes -> gnt=0 and outputs unchanged; out_ready=1 with a new request -> new winner loaded next cycle with no bubble.
REQ-035 flush=1 in a cycle with req=0xFFFF and out_valid=1 -> gnt=0, out_valid=0 next cycle.
REQ-036 Reset mid-stall, and a randomized run at REQ_NUM=4/32/64 against a reference age model -> outputs zero immediately on reset; across 10k random cycles every out_idx matches the model and gnt is one-hot or zero.
